// File: rtl/noise_monitor.sv
// noise_monitor: rebuilds the PSG noise LFSR sequence from its output bits,
// predicts the next bit, locks after a run of correct predictions, counts
// mismatches while locked and measures the clk interval between LFSR steps.
module noise_monitor #(
    parameter int unsigned LFSR_BITS     = 17,
    parameter int unsigned LFSR_TAP0     = 0,
    parameter int unsigned LFSR_TAP1     = 3,
    parameter int unsigned INVERTED      = 1,
    parameter int unsigned LOCK_COUNT    = 32,
    parameter int unsigned ERR_BITS      = 8,
    parameter int unsigned INTERVAL_BITS = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     sample_valid,
    input  logic                     noise_in,
    output logic                     locked,
    output logic                     error,
    output logic [ERR_BITS-1:0]      err_count,
    output logic                     predicted,
    output logic                     predict_valid,
    output logic [INTERVAL_BITS-1:0] interval,
    output logic                     interval_valid
);

    localparam int unsigned FillW  = $clog2(LFSR_BITS + 1);
    localparam int unsigned RunW   = 8;
    localparam logic        InvBit = (INVERTED != 0);

    typedef enum logic [1:0] {StAcquire, StCheck, StLocked} state_e;

    state_e                   state_q, state_d;
    logic [LFSR_BITS-1:0]     hist_q, hist_d;
    logic [FillW-1:0]         fill_q, fill_d;
    logic [RunW-1:0]          run_q, run_d;
    logic [ERR_BITS-1:0]      err_q, err_d;
    logic                     error_q, error_d;
    logic [INTERVAL_BITS-1:0] gap_q, interval_q;
    logic                     seen_q, interval_valid_q;

    logic obs;
    logic pred;
    logic match;

    // Observed bit in the LFSR domain and the prediction from history.
    // The all-zero term mirrors the generator's escape from the lock-up state.
    always_comb begin
        obs   = noise_in ^ InvBit;
        pred  = (hist_q[LFSR_BITS-1-LFSR_TAP0] ^ hist_q[LFSR_BITS-1-LFSR_TAP1])
                | (hist_q == '0);
        match = (obs == pred);
    end

    // Next-state logic for history, acquisition/lock FSM and error counter.
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        run_d   = run_q;
        err_d   = err_q;
        error_d = 1'b0;
        if (clear) begin
            state_d = StAcquire;
            hist_d  = '0;
            fill_d  = '0;
            run_d   = '0;
            err_d   = '0;
        end else if (sample_valid) begin
            // History always takes the real bit, so a mismatch resyncs by itself.
            hist_d = {hist_q[LFSR_BITS-2:0], obs};
            unique case (state_q)
                StAcquire: begin
                    if (fill_q == FillW'(LFSR_BITS - 1)) begin
                        state_d = StCheck;
                        fill_d  = '0;
                        run_d   = '0;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                StCheck: begin
                    if (!match) begin
                        run_d = '0;
                    end else if (run_q == RunW'(LOCK_COUNT - 1)) begin
                        state_d = StLocked;
                        run_d   = '0;
                    end else begin
                        run_d = run_q + 1'b1;
                    end
                end
                StLocked: begin
                    if (!match) begin
                        error_d = 1'b1;
                        state_d = StCheck;
                        run_d   = '0;
                        if (err_q != '1) err_d = err_q + 1'b1;
                    end
                end
                default: state_d = StAcquire;
            endcase
        end
    end

    // Lock FSM, history and error state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StAcquire;
            hist_q  <= '0;
            fill_q  <= '0;
            run_q   <= '0;
            err_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            run_q   <= run_d;
            err_q   <= err_d;
            error_q <= error_d;
        end
    end

    // Step-interval measurement; the first sample after reset/clear only arms it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_q            <= '0;
            seen_q           <= 1'b0;
            interval_q       <= '0;
            interval_valid_q <= 1'b0;
        end else if (clear) begin
            gap_q            <= '0;
            seen_q           <= 1'b0;
            interval_q       <= '0;
            interval_valid_q <= 1'b0;
        end else if (sample_valid) begin
            gap_q  <= INTERVAL_BITS'(1);
            seen_q <= 1'b1;
            if (seen_q) begin
                interval_q       <= gap_q;
                interval_valid_q <= 1'b1;
            end
        end else if (gap_q != '1) begin
            gap_q <= gap_q + 1'b1;
        end
    end

    // Outputs; the prediction is held low while it carries no meaning so that
    // every output reads zero straight out of reset.
    always_comb begin
        locked         = (state_q == StLocked);
        predict_valid  = (state_q != StAcquire);
        predicted      = pred & predict_valid;
        error          = error_q;
        err_count      = err_q;
        interval       = interval_q;
        interval_valid = interval_valid_q;
    end

endmodule

// File: tb/tb_noise_monitor.sv
// tb_noise_monitor: directed bench for noise_monitor against a reference
// 17-bit noise LFSR; a second instance covers INVERTED=0, LOCK_COUNT=1.
module tb_noise_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        sample_valid;
    logic        noise_in;
    logic        noise2;
    logic        locked, error, predicted, predict_valid, interval_valid;
    logic [7:0]  err_count;
    logic [15:0] interval;
    logic        locked2, error2, predicted2, predict_valid2, interval_valid2;
    logic [7:0]  err_count2;
    logic [15:0] interval2;

    logic [16:0] lfsr;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    noise_monitor dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (clear),
        .sample_valid   (sample_valid),
        .noise_in       (noise_in),
        .locked         (locked),
        .error          (error),
        .err_count      (err_count),
        .predicted      (predicted),
        .predict_valid  (predict_valid),
        .interval       (interval),
        .interval_valid (interval_valid)
    );

    noise_monitor #(
        .INVERTED   (0),
        .LOCK_COUNT (1)
    ) dut2 (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (clear),
        .sample_valid   (sample_valid),
        .noise_in       (noise2),
        .locked         (locked2),
        .error          (error2),
        .err_count      (err_count2),
        .predicted      (predicted2),
        .predict_valid  (predict_valid2),
        .interval       (interval2),
        .interval_valid (interval_valid2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Next generator bit: shift-left Fibonacci LFSR with all-zero escape.
    function automatic logic next_bit(input logic [16:0] s);
        return (s[16] ^ s[13]) | (s == 17'd0);
    endfunction

    // One LFSR step presented as a one-cycle strobe, then gap-1 idle cycles.
    // Called and returns on a negedge; strobes are gap cycles apart.
    task automatic send(input int gap, input bit flip);
        logic b;
        b            = next_bit(lfsr);
        lfsr         = {lfsr[15:0], b};
        sample_valid = 1'b1;
        noise_in     = ~b ^ flip;
        noise2       = b;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    initial begin
        logic b;
        rst_n        = 1'b0;
        clear        = 1'b0;
        sample_valid = 1'b0;
        noise_in     = 1'b0;
        noise2       = 1'b0;
        lfsr         = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {locked, error, err_count, predicted, predict_valid,
                                interval, interval_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Lock from reset, one sample every 10 cycles.
        for (int i = 1; i <= 49; i++) begin
            send(10, 1'b0);
            if (i == 16) check("pv_before_fill", predict_valid, 1'b0);
            if (i == 17) check("pv_after_fill", predict_valid, 1'b1);
            if (i == 17) check("cfg2_unlocked_17", locked2, 1'b0);
            if (i == 18) check("cfg2_locked_18", locked2, 1'b1);
            if (i == 48) check("unlocked_48", locked, 1'b0);
        end
        check("locked_49", locked, 1'b1);
        check("err_zero", err_count, 8'd0);
        check("interval_10", interval, 16'd10);
        check("interval_valid", interval_valid, 1'b1);
        check("predicted_next", predicted, next_bit(lfsr));

        // Single corrupted bit at sample 60.
        for (int i = 50; i <= 59; i++) send(10, 1'b0);
        send(1, 1'b1);
        check("error_pulse", error, 1'b1);
        check("err_count_1", err_count, 8'd1);
        check("unlocked_on_err", locked, 1'b0);
        @(negedge clk);
        check("error_one_cycle", error, 1'b0);
        for (int i = 61; i <= 109; i++) begin
            send(1, 1'b0);
            if (i == 74 || i == 77) begin
                check("check_err_hold", err_count, 8'd1);
                check("check_no_pulse", error, 1'b0);
                check("check_unlocked", locked, 1'b0);
            end
            if (i == 108) check("unlocked_108", locked, 1'b0);
        end
        check("relocked_109", locked, 1'b1);

        // Clear colliding with a sample while locked.
        b            = next_bit(lfsr);
        lfsr         = {lfsr[15:0], b};
        clear        = 1'b1;
        sample_valid = 1'b1;
        noise_in     = ~b;
        noise2       = b;
        @(negedge clk);
        clear        = 1'b0;
        sample_valid = 1'b0;
        check("clr_locked", locked, 1'b0);
        check("clr_err", err_count, 8'd0);
        check("clr_pv", predict_valid, 1'b0);
        check("clr_iv", interval_valid, 1'b0);
        for (int i = 1; i <= 49; i++) begin
            send(1, 1'b0);
            if (i == 1) check("clr_iv_armed", interval_valid, 1'b0);
            if (i == 2) check("clr_iv_set", interval_valid, 1'b1);
            if (i == 2) check("clr_interval_1", interval, 16'd1);
            if (i == 16) check("clr_pv_16", predict_valid, 1'b0);
            if (i == 17) check("clr_pv_17", predict_valid, 1'b1);
            if (i == 48) check("clr_unlocked_48", locked, 1'b0);
        end
        check("clr_relocked", locked, 1'b1);

        // Error counter saturation: 300 locked mismatches.
        repeat (300) begin
            send(1, 1'b1);
            repeat (49) send(1, 1'b0);
        end
        check("err_saturated", err_count, 8'd255);
        check("sat_relocked", locked, 1'b1);

        // Interval saturation.
        send(70000, 1'b0);
        send(1, 1'b0);
        check("interval_sat", interval, 16'hffff);

        // Async reset mid-CHECK.
        send(1, 1'b1);
        check("sat_hold", err_count, 8'd255);
        check("in_check", locked, 1'b0);
        repeat (5) send(3, 1'b0);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {locked, error, err_count, predicted, predict_valid,
                                      interval, interval_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 49; i++) begin
            send(2, 1'b0);
            if (i == 48) check("rst_unlocked_48", locked, 1'b0);
        end
        check("rst_relocked_49", locked, 1'b1);
        check("rst_err_zero", err_count, 8'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
